// File: rtl/lfsr_checker_if.sv
// Stream and status bundle for the x^10+x^7+1 receive-side checker.
// The master drives the received stream and controls; the slave (checker) returns lock/error status.
interface lfsr_checker_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 in_valid;
    logic [9:0]           in_val;
    logic                 resync;
    logic                 clear_counts;
    logic                 locked;
    logic                 err_pulse;
    logic                 loss_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 zero_seen;

    modport master (
        output in_valid, in_val, resync, clear_counts,
        input  locked, err_pulse, loss_pulse, err_count, zero_seen
    );

    modport slave (
        input  in_valid, in_val, resync, clear_counts,
        output locked, err_pulse, loss_pulse, err_count, zero_seen
    );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 10-bit x^10+x^7+1 stream: acquires lock from the incoming
// words, then flywheels its own reference to count mismatches and detect loss of sync.
module lfsr_checker #(
    parameter int LOCK_CNT  = 8,
    parameter int LOSS_CNT  = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lfsr_checker_if.slave bus_if
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    localparam logic [GW-1:0]        GOOD_ONE  = GW'(1);
    localparam logic [GW-1:0]        GOOD_LOCK = GW'(LOCK_CNT);
    localparam logic [BW-1:0]        BAD_ONE   = BW'(1);
    localparam logic [BW-1:0]        BAD_LOSS  = BW'(LOSS_CNT);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE   = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Successor of a state on the x^10+x^7+1 sequence.
    function automatic logic [9:0] lfsr_nxt(input logic [9:0] x);
        return {x[8:0], x[9] ^ x[6]};
    endfunction

    state_e               state_q,      state_d;
    logic [9:0]           ref_q,        ref_d;
    logic [GW-1:0]        good_q,       good_d;
    logic [BW-1:0]        bad_q,        bad_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;
    logic                 zero_q,       zero_d;
    logic                 locked_q,     locked_d;
    logic                 err_pulse_q,  err_pulse_d;
    logic                 loss_pulse_q, loss_pulse_d;

    logic                 word_zero_s;
    logic                 match_s;
    logic                 err_inc_s;
    logic                 zero_set_s;

    // Acquisition / flywheel state machine plus counter next-state.
    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        good_d       = good_q;
        bad_d        = bad_q;
        err_pulse_d  = 1'b0;
        loss_pulse_d = 1'b0;
        err_inc_s    = 1'b0;
        zero_set_s   = 1'b0;
        word_zero_s  = (bus_if.in_val == 10'd0);
        match_s      = (bus_if.in_val == ref_q);

        if (bus_if.resync) begin
            // The word presented alongside resync is deliberately discarded.
            state_d = ST_HUNT;
            good_d  = '0;
            bad_d   = '0;
        end else if (bus_if.in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (word_zero_s) begin
                        zero_set_s = 1'b1;
                    end else begin
                        ref_d   = lfsr_nxt(bus_if.in_val);
                        good_d  = GOOD_ONE;
                        state_d = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (word_zero_s) begin
                        zero_set_s = 1'b1;
                        good_d     = '0;
                        state_d    = ST_HUNT;
                    end else if (match_s) begin
                        ref_d = lfsr_nxt(bus_if.in_val);
                        if (good_q + GOOD_ONE == GOOD_LOCK) begin
                            good_d  = '0;
                            bad_d   = '0;
                            state_d = ST_LOCKED;
                        end else begin
                            good_d = good_q + GOOD_ONE;
                        end
                    end else begin
                        // Any nonzero word is a plausible new seed.
                        ref_d  = lfsr_nxt(bus_if.in_val);
                        good_d = GOOD_ONE;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the reference advances whether or not the word matched.
                    ref_d = lfsr_nxt(ref_q);
                    if (match_s) begin
                        bad_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc_s   = 1'b1;
                        zero_set_s  = word_zero_s;
                        if (bad_q + BAD_ONE == BAD_LOSS) begin
                            bad_d        = '0;
                            loss_pulse_d = 1'b1;
                            state_d      = ST_HUNT;
                        end else begin
                            bad_d = bad_q + BAD_ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // clear_counts overrides any increment or sticky set in the same cycle.
        if (bus_if.clear_counts) begin
            err_cnt_d = '0;
            zero_d    = 1'b0;
        end else begin
            if (err_inc_s && (err_cnt_q != ERR_MAX)) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            zero_d = zero_q | zero_set_s;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State, reference and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_HUNT;
            ref_q        <= 10'd0;
            good_q       <= '0;
            bad_q        <= '0;
            err_cnt_q    <= '0;
            zero_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            loss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            err_cnt_q    <= err_cnt_d;
            zero_q       <= zero_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            loss_pulse_q <= loss_pulse_d;
        end
    end

    assign bus_if.locked     = locked_q;
    assign bus_if.err_pulse  = err_pulse_q;
    assign bus_if.loss_pulse = loss_pulse_q;
    assign bus_if.err_count  = err_cnt_q;
    assign bus_if.zero_seen  = zero_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed scoreboard bench for lfsr_checker: each driven word pushes its expected registered
// status, which is popped and compared one cycle later.
module tb_lfsr_checker;
    localparam int EW = 4;

    typedef struct packed {
        logic          locked;
        logic          errp;
        logic          lossp;
        logic [EW-1:0] cnt;
        logic          zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lfsr_checker_if #(.ERR_CNT_W(EW)) bus ();

    lfsr_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .ERR_CNT_W(EW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    exp_t          sb_q[$];
    int            tests = 0;
    int            fails = 0;
    int            step_no = 0;
    logic [9:0]    gen;
    logic [EW-1:0] exp_cnt = '0;
    logic          exp_zero = 1'b0;

    function automatic logic [9:0] nxt(input logic [9:0] x);
        return {x[8:0], x[9] ^ x[6]};
    endfunction

    task automatic check_out();
        exp_t e;
        tests++;
        assert (sb_q.size() > 0) else begin
            fails++;
            $error("FAIL scoreboard_empty step %0d: got 0 entries, need 1", step_no);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tests++;
            assert (bus.locked === e.locked) else begin
                fails++;
                $error("FAIL locked step %0d: got %b exp %b", step_no, bus.locked, e.locked);
            end
            tests++;
            assert (bus.err_pulse === e.errp) else begin
                fails++;
                $error("FAIL err_pulse step %0d: got %b exp %b", step_no, bus.err_pulse, e.errp);
            end
            tests++;
            assert (bus.loss_pulse === e.lossp) else begin
                fails++;
                $error("FAIL loss_pulse step %0d: got %b exp %b", step_no, bus.loss_pulse, e.lossp);
            end
            tests++;
            assert (bus.err_count === e.cnt) else begin
                fails++;
                $error("FAIL err_count step %0d: got %0d exp %0d", step_no, bus.err_count, e.cnt);
            end
            tests++;
            assert (bus.zero_seen === e.zero) else begin
                fails++;
                $error("FAIL zero_seen step %0d: got %b exp %b", step_no, bus.zero_seen, e.zero);
            end
        end
    endtask

    task automatic step(input logic v, input logic [9:0] w, input logic rs, input logic clr,
                        input logic e_lk, input logic e_ep, input logic e_lp);
        exp_t e;
        bus.in_valid     = v;
        bus.in_val       = w;
        bus.resync       = rs;
        bus.clear_counts = clr;
        e.locked = e_lk;
        e.errp   = e_ep;
        e.lossp  = e_lp;
        e.cnt    = exp_cnt;
        e.zero   = exp_zero;
        sb_q.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic bump();
        if (exp_cnt != {EW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    endtask

    // n in-sequence words; locked is expected from word index lock_at onward.
    task automatic clean(input int n, input int lock_at);
        for (int i = 0; i < n; i++) begin
            step(1'b1, gen, 1'b0, 1'b0, (i >= lock_at), 1'b0, 1'b0);
            gen = nxt(gen);
        end
    endtask

    // One corrupted word while locked; the generator still advances.
    task automatic bad(input logic [9:0] m, input logic e_lk, input logic e_lp);
        bump();
        if ((gen ^ m) == 10'd0) exp_zero = 1'b1;
        step(1'b1, gen ^ m, 1'b0, 1'b0, e_lk, 1'b1, e_lp);
        gen = nxt(gen);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_val = 10'd0;
        bus.resync = 1'b0;
        bus.clear_counts = 1'b0;

        // Reset state, even with a valid word presented.
        rst = 1'b1;
        step(1'b1, 10'h001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Long clean stream from 10'h001 across two full wraps.
        gen = 10'h001;
        clean(2100, 7);

        // Single bit error: one pulse, flywheel keeps following.
        bad(10'h001, 1'b1, 1'b0);
        clean(20, 0);

        // Four consecutive errors drop lock; then relock.
        bad(10'h3FF, 1'b1, 1'b0);
        bad(10'h3FF, 1'b1, 1'b0);
        bad(10'h3FF, 1'b1, 1'b0);
        bad(10'h3FF, 1'b0, 1'b1);
        clean(12, 7);

        // Reseed with resync: no errors, relock after 8 words.
        step(1'b1, 10'h2A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        gen = nxt(10'h2A5);
        clean(12, 7);

        // Reseed without resync: four errors, loss, then relock.
        gen = 10'h2A5;
        for (int j = 0; j < 4; j++) begin
            bump();
            step(1'b1, gen, 1'b0, 1'b0, (j < 3), 1'b1, (j == 3));
            gen = nxt(gen);
        end
        clean(12, 7);

        // Zero words in HUNT set zero_seen and stay hunting.
        step(1'b1, gen, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_zero = 1'b1;
        step(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clean(10, 7);

        // Gaps of 1-5 idle cycles while locked.
        for (int g = 1; g <= 5; g++) begin
            for (int k = 0; k < g; k++) begin
                step(1'b0, 10'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            clean(2, 0);
        end

        // clear_counts coincident with an error wins.
        exp_cnt = '0;
        exp_zero = 1'b0;
        step(1'b1, gen ^ 10'h001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        gen = nxt(gen);
        clean(2, 0);

        // Saturation: err_count holds at max, pulses keep firing.
        for (int s = 0; s < 20; s++) begin
            bad(10'h010, 1'b1, 1'b0);
            clean(1, 0);
        end

        // Plain clear, then build err_count to 5.
        exp_cnt = '0;
        exp_zero = 1'b0;
        step(1'b1, gen, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        gen = nxt(gen);
        for (int s = 0; s < 5; s++) begin
            bad(10'h100, 1'b1, 1'b0);
            clean(1, 0);
        end

        // Reset mid-stream while locked with err_count=5.
        rst = 1'b1;
        exp_cnt = '0;
        exp_zero = 1'b0;
        step(1'b1, gen, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        gen = 10'h001;
        clean(10, 7);

        // clear_counts beats a same-cycle zero_seen set; then zero sets it.
        step(1'b1, gen, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_zero = 1'b1;
        step(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
